// File: rtl/obuf_drain_pkg.sv
// Shared types and default widths for the output-buffer drain engine.
// Address width default matches the output-buffer memory-side configuration.
package obuf_drain_pkg;

    localparam int DEF_MEM_DATA_WIDTH = 64;
    localparam int DEF_MEM_ADDR_WIDTH = 11;
    localparam int DEF_LEN_W          = 16;
    localparam int DEF_FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } drain_state_t;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/obuf_drain_fifo.sv
// Small synchronous skid FIFO: register-array storage, head word presented
// from registers, occupancy count exported for credit tracking.
module obuf_drain_fifo
    import obuf_drain_pkg::*;
#(
    parameter int WIDTH = DEF_MEM_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    output logic [occ_width(DEPTH)-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Entries are reset so the stream data output reads zero out of reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_mem[gi] <= '0;
            end else if (i_push && (r_wr_ptr == PTR_W'(gi))) begin
                r_mem[gi] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/obuf_drain.sv
// Drain engine: streams a run of output-buffer words into a ready/valid stream,
// issuing a read only when the returned word is guaranteed a FIFO slot.
module obuf_drain
    import obuf_drain_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0]          num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      obuf_read_req,
    output logic [MEM_ADDR_WIDTH-1:0] obuf_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] obuf_read_data,
    output logic [MEM_DATA_WIDTH-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last
);

    localparam int OCC_W = occ_width(FIFO_DEPTH);
    localparam logic [OCC_W:0] CREDITS = (OCC_W + 1)'(FIFO_DEPTH);

    drain_state_t              r_state;
    drain_state_t              w_state_next;
    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_W-1:0]          r_remaining;
    logic [LEN_W-1:0]          r_last_idx;
    logic [LEN_W-1:0]          r_pop_cnt;
    logic                      r_inflight;

    logic [OCC_W-1:0]          w_occ;
    logic [OCC_W:0]            w_committed;
    logic                      w_issue;
    logic                      w_pop;
    logic                      w_fifo_valid;
    logic                      w_last;

    // Words already buffered plus the one still coming back from memory.
    assign w_committed = {1'b0, w_occ} + (OCC_W + 1)'(r_inflight);
    assign w_issue     = (r_state == ST_ISSUE) && (r_remaining != '0) && (w_committed < CREDITS);
    assign w_pop       = w_fifo_valid && m_ready;
    assign w_last      = w_fifo_valid && (r_pop_cnt == r_last_idx);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_words == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_issue && (r_remaining == LEN_W'(1))) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_pop && w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_last_idx  <= '0;
            r_pop_cnt   <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if ((r_state == ST_IDLE) && start) begin
                r_addr      <= base_addr;
                r_remaining <= num_words;
                r_last_idx  <= num_words - LEN_W'(1);
                r_pop_cnt   <= '0;
            end else begin
                if (w_issue) begin
                    r_addr      <= r_addr + MEM_ADDR_WIDTH'(1);
                    r_remaining <= r_remaining - LEN_W'(1);
                end
                if (w_pop) begin
                    r_pop_cnt <= r_pop_cnt + LEN_W'(1);
                end
            end
        end
    end

    obuf_drain_fifo #(
        .WIDTH (MEM_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data (obuf_read_data),
        .i_pop       (w_pop),
        .o_data      (m_data),
        .o_valid     (w_fifo_valid),
        .o_count     (w_occ)
    );

    assign busy           = (r_state == ST_ISSUE) || (r_state == ST_FLUSH);
    assign done           = (r_state == ST_DONE);
    assign obuf_read_req  = w_issue;
    assign obuf_read_addr = r_addr;
    assign m_valid        = w_fifo_valid;
    assign m_last         = w_last;

endmodule

// File: doc/obuf_drain.md
# obuf_drain

Drain engine sitting directly downstream of the output buffer's memory-side read port. On a `start` command it streams `num_words` consecutive `MEM_DATA_WIDTH` words out of the output buffer into a ready/valid stream toward the memory write path (AXI write-data packer). It absorbs the buffer's fixed 1-cycle read latency and downstream backpressure with a small credit-guarded FIFO, so the buffer is never read unless the result has a guaranteed slot.

## Interface
Parameters:
- `MEM_DATA_WIDTH`, 64, width of one output-buffer memory word
- `MEM_ADDR_WIDTH`, 11, output-buffer memory-side address width (bank address plus bank-ID LSBs)
- `LEN_W`, 16, width of the word-count field
- `FIFO_DEPTH`, 4, skid FIFO entries; power of two, minimum 2

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle command strobe; sampled only in IDLE
- `base_addr`  in  MEM_ADDR_WIDTH  first output-buffer memory address
- `num_words`  in  LEN_W  number of words to drain
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle completion pulse
- `obuf_read_req`  out  1  output-buffer memory read request
- `obuf_read_addr`  out  MEM_ADDR_WIDTH  output-buffer memory read address
- `obuf_read_data`  in  MEM_DATA_WIDTH  read data, valid the cycle after `obuf_read_req`
- `m_data`  out  MEM_DATA_WIDTH  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready
- `m_last`  out  1  marks final word of the command

## Operation
- FSM states: IDLE, ISSUE, FLUSH, DONE.
- IDLE: `start`=1 latches `base_addr` into the address counter and `num_words` into the remaining-issue counter, then moves to ISSUE; if `num_words`==0, moves to DONE instead and issues no reads.
- ISSUE: asserts `obuf_read_req` when `occupancy + inflight < FIFO_DEPTH` (registered values; `inflight` = 1 if a read was issued last cycle). Each issue increments the address by 1, wrapping modulo 2^MEM_ADDR_WIDTH, and decrements the remaining count. Moves to FLUSH after the final issue.
- FLUSH: waits until the final word completes its handshake (`m_valid & m_ready & m_last`), then moves to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- A returned read word is always pushed into the FIFO in the cycle it arrives; the credit rule guarantees no overflow. Push and pop in the same cycle leave occupancy unchanged.
- `m_last` is high with the word whose sequence index equals `num_words-1`; a separate pop counter tracks this.
- `m_data`/`m_valid`/`m_last` hold stable while `m_valid & !m_ready`.
- `start` in any state other than IDLE is ignored.
- Reset values: `busy`=0, `done`=0, `obuf_read_req`=0, `obuf_read_addr`=0, `m_valid`=0, `m_last`=0, `m_data`=0. FIFO pointers, counters and the FSM clear. Assertion of `reset_n` mid-command drops all in-flight and buffered words immediately. No `done` is produced for the aborted command.

## Timing
- `start` sampled at edge 0 → first `obuf_read_req` at cycle 1 → data on `obuf_read_data` at cycle 2, written into the FIFO at edge 3 → `m_valid` at cycle 3.
- With `m_ready` held high, the block sustains one word per cycle. N words complete handshakes at cycles 3 … N+2. `done` is asserted at cycle N+3.
- With `m_ready` low, issue stalls once `occupancy + inflight` reaches FIFO_DEPTH; at most FIFO_DEPTH reads are outstanding or buffered.
- `num_words`=0: `done` is asserted at cycle 1, and `busy` stays 0.
- `busy` falls in the same cycle `done` is asserted.

## Structure
- The shared package holds the FSM state enum (IDLE/ISSUE/FLUSH/DONE) and the default width constants, so the address width matches the output-buffer configuration.
- One sub-module, `obuf_drain_fifo`: a synchronous FIFO with push, pop, registered output, and an occupancy count, with the same async active-low reset.
- The FSM, the issue/address counters, the credit logic and the last-word counter live in the top level.

## Test plan
- `base_addr`=0x010, `num_words`=8, `m_ready`=1 → reads are issued to 0x010–0x017 on cycles 1–8; 8 words stream on cycles 3–10 in order; `m_last` is high on the 8th word; `done` is asserted at cycle 11.
- Same command with `m_ready` low for 10 cycles after cycle 3 → exactly 4 reads are issued before the stall; there is no FIFO overflow; all 8 words arrive in order after release.
- `base_addr`=0x7FE, `num_words`=4 → read addresses are 0x7FE, 0x7FF, 0x000, 0x001.
- `num_words`=0 → no `obuf_read_req`, `busy` stays 0, and `done` is asserted at cycle 1.
- `start` pulsed again while busy with `num_words`=3 → it is ignored; only the original command's words and one `done` appear.
- `reset_n` asserted low at cycle 5 of an 8-word command → all outputs are 0 immediately; after release the block is in IDLE and a new 2-word command completes normally.
